// File: rtl/neuron_weight_feeder.sv
// neuron_weight_feeder
//   Supply side of the neuron weight-stream interface. On a start pulse it latches a
//   job (base address, weight count, initial vmem), prefetches the weight list from a
//   synchronous memory through a 2-entry buffer, streams it to a PIF neuron on
//   readyMem, raises finished for a hold window, then captures the neuron's vmem and
//   spike and pulses done.
//
//   Optional feature: define FEEDER_UNDERFLOW_CNT_EN to build the saturating 8-bit
//   underflowCount; otherwise underflowCount is tied to 0.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle job request, accepted only in IDLE
//   baseAddr          first weight address (latched on start)
//   numWeights        number of weights, 0 allowed (latched on start)
//   vmemInit          initial membrane value (latched on start, driven on vmemIn)
//   memRdEn, memAddr  weight memory read strobe / address
//   memRdData         read data, valid the cycle after memRdEn
//   readyMem          neuron consumes weightData this cycle
//   weightData        buffer head, 0 when empty
//   vmemIn            latched vmemInit
//   finished          end-of-list indication to the neuron
//   neurVmem          neuron vmemOut
//   neurSpike         neuron spikeBuffer
//   busy              job in progress (STREAM, DRAIN, CAPTURE)
//   done              one-cycle pulse, results valid
//   vmemResult        captured neurVmem
//   spikeResult       captured neurSpike
//   underflow         sticky: readyMem seen while the buffer was empty
//   underflowCount    saturating underflow cycle count
module neuron_weight_feeder #(
  parameter int unsigned INTEGER_WIDTH  = 8,
  parameter int unsigned FRACTION_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = INTEGER_WIDTH + FRACTION_WIDTH,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned FINISH_HOLD    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     baseAddr,
  input  logic [ADDR_WIDTH-1:0]     numWeights,
  input  logic [DATA_WIDTH-1:0]     vmemInit,
  output logic                      memRdEn,
  output logic [ADDR_WIDTH-1:0]     memAddr,
  input  logic [FRACTION_WIDTH-1:0] memRdData,
  input  logic                      readyMem,
  output logic [FRACTION_WIDTH-1:0] weightData,
  output logic [DATA_WIDTH-1:0]     vmemIn,
  output logic                      finished,
  input  logic [DATA_WIDTH-1:0]     neurVmem,
  input  logic                      neurSpike,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     vmemResult,
  output logic                      spikeResult,
  output logic                      underflow,
  output logic [7:0]                underflowCount
);

  localparam int unsigned HoldW = $clog2(FINISH_HOLD + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStream,
    StDrain,
    StCapture,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     base_q, num_q, issued_q, consumed_q;
  logic [DATA_WIDTH-1:0]     vmem_in_q, vres_q;
  logic                      spike_q, uf_q;
  logic [FRACTION_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]                occ_q, occ_d, occ_after_pop;
  logic                      pend_q;
  logic [HoldW-1:0]          hold_q, hold_d;

  logic accept, pop, push, rd_en, uf_evt, in_stream;

  assign in_stream = (state_q == StStream);
  assign accept    = (state_q == StIdle) && start;
  assign pop       = in_stream && readyMem && (occ_q != 2'd0);
  assign push      = pend_q;
  assign uf_evt    = in_stream && readyMem && (occ_q == 2'd0) && (consumed_q < num_q);

  // The slot freed by this cycle's pop counts as available, so a continuously ready
  // neuron is served one weight per cycle despite the one-cycle memory latency.
  assign occ_after_pop = occ_q - {1'b0, pop};
  assign rd_en = in_stream && (issued_q < num_q) &&
                 (({1'b0, occ_after_pop} + {2'b00, pend_q}) < 3'd2);

  // Two-entry buffer: buf0 is the head; a pop shifts buf1 forward before the push lands.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    if (pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) begin
        buf0_d = memRdData;
      end else begin
        buf1_d = memRdData;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StStream;
      end
      StStream: begin
        if (consumed_q == num_q) begin
          state_d = StDrain;
          hold_d  = HoldW'(FINISH_HOLD);
        end
      end
      StDrain: begin
        hold_d = (hold_q != '0) ? hold_q - HoldW'(1) : '0;
        // The neuron must have released readyMem before results are sampled.
        if ((hold_d == '0) && !readyMem) state_d = StCapture;
      end
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      consumed_q <= '0;
      vmem_in_q  <= '0;
      vres_q     <= '0;
      spike_q    <= 1'b0;
      uf_q       <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      pend_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      occ_q   <= occ_d;
      pend_q  <= rd_en;
      if (accept) begin
        base_q     <= baseAddr;
        num_q      <= numWeights;
        vmem_in_q  <= vmemInit;
        issued_q   <= '0;
        consumed_q <= '0;
        uf_q       <= 1'b0;
      end else begin
        if (rd_en)  issued_q   <= issued_q + ADDR_WIDTH'(1);
        if (pop)    consumed_q <= consumed_q + ADDR_WIDTH'(1);
        if (uf_evt) uf_q       <= 1'b1;
      end
      if (state_q == StCapture) begin
        vres_q  <= neurVmem;
        spike_q <= neurSpike;
      end
    end
  end

`ifdef FEEDER_UNDERFLOW_CNT_EN
  logic [7:0] uf_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      uf_cnt_q <= 8'd0;
    end else if (uf_evt && (uf_cnt_q != 8'hFF)) begin
      uf_cnt_q <= uf_cnt_q + 8'd1;
    end
  end

  assign underflowCount = uf_cnt_q;
`else
  assign underflowCount = 8'd0;
`endif

  assign memRdEn     = rd_en;
  assign memAddr     = base_q + issued_q;
  assign weightData  = (occ_q != 2'd0) ? buf0_q : '0;
  assign vmemIn      = vmem_in_q;
  assign finished    = (state_q == StDrain);
  assign busy        = (state_q == StStream) || (state_q == StDrain) || (state_q == StCapture);
  assign done        = (state_q == StDone);
  assign vmemResult  = vres_q;
  assign spikeResult = spike_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_neuron_weight_feeder.sv
// Bench for neuron_weight_feeder: table of directed jobs with end-of-job expectations,
// hand sequences for reset state and abort, then randomized jobs. Every cycle is
// compared against a queue-based reference of the weight stream.
module tb_neuron_weight_feeder;
  localparam int FH = 4;

  logic        clk = 1'b0;
  logic        reset, start, readyMem, neurSpike;
  logic [9:0]  baseAddr, numWeights, memAddr;
  logic [15:0] vmemInit, vmemIn, neurVmem, vmemResult;
  logic        memRdEn, finished, busy, done, spikeResult, underflow;
  logic [7:0]  memRdData, weightData, underflowCount;

  always #5 clk = ~clk;

  neuron_weight_feeder dut (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
    .numWeights(numWeights), .vmemInit(vmemInit), .memRdEn(memRdEn), .memAddr(memAddr),
    .memRdData(memRdData), .readyMem(readyMem), .weightData(weightData), .vmemIn(vmemIn),
    .finished(finished), .neurVmem(neurVmem), .neurSpike(neurSpike), .busy(busy),
    .done(done), .vmemResult(vmemResult), .spikeResult(spikeResult),
    .underflow(underflow), .underflowCount(underflowCount)
  );

  logic [7:0] mem [1024];
  always @(posedge clk) if (memRdEn) memRdData <= mem[memAddr];

  // Reference: phase 0 idle, 1 stream, 2 drain, 3 capture, 4 done.
  int         m_ph, m_base, m_n, m_issued, m_consumed, m_hold, m_cnt;
  logic [7:0] q[$];
  logic [7:0] fly[$];
  bit         m_uf, m_sres;
  logic [15:0] m_vin, m_vres;

  int n_vec = 0, n_bad = 0, cyc = 0;
  int obs_reads, obs_fin, obs_pops, obs_done;

  task automatic model_reset();
    m_ph = 0; m_base = 0; m_n = 0; m_issued = 0; m_consumed = 0; m_hold = 0; m_cnt = 0;
    q.delete(); fly.delete(); m_uf = 0; m_sres = 0; m_vin = '0; m_vres = '0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare one cycle at the falling edge, then advance the reference to the next edge.
  task automatic cycle();
    bit         pop, e_rden;
    int         e_addr, e_cnt, old_cons, nph;
    logic [7:0] e_wd;
    @(negedge clk);
    pop    = (m_ph == 1) && readyMem && (q.size() > 0);
    e_rden = (m_ph == 1) && (m_issued < m_n) && ((q.size() - int'(pop) + fly.size()) < 2);
    e_addr = (m_base + m_issued) % 1024;
    e_wd   = (q.size() > 0) ? q[0] : 8'd0;
`ifdef FEEDER_UNDERFLOW_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 0;
`endif
    n_vec++;
    if (memRdEn !== e_rden || memAddr !== 10'(e_addr) || weightData !== e_wd ||
        vmemIn !== m_vin || finished !== (m_ph == 2) || busy !== (m_ph >= 1 && m_ph <= 3) ||
        done !== (m_ph == 4) || underflow !== m_uf || vmemResult !== m_vres ||
        spikeResult !== m_sres || int'(underflowCount) != e_cnt) begin
      n_bad++;
      $display("FAIL cycle %0d: got rden=%b addr=%h wd=%h vin=%h fin=%b busy=%b done=%b uf=%b vres=%h spk=%b ufc=%0d; expected rden=%b addr=%h wd=%h vin=%h fin=%b busy=%b done=%b uf=%b vres=%h spk=%b ufc=%0d",
               cyc, memRdEn, memAddr, weightData, vmemIn, finished, busy, done, underflow,
               vmemResult, spikeResult, underflowCount, e_rden, 10'(e_addr), e_wd, m_vin,
               m_ph == 2, m_ph >= 1 && m_ph <= 3, m_ph == 4, m_uf, m_vres, m_sres, e_cnt);
    end
    if (memRdEn) obs_reads++;
    if (finished) obs_fin++;
    if (done) obs_done++;
    if (busy && !finished && readyMem && weightData != 8'd0) obs_pops++;

    if (reset) begin
      model_reset();
    end else begin
      old_cons = m_consumed;
      nph = m_ph;
      if ((m_ph == 1) && readyMem && (q.size() == 0) && (m_consumed < m_n)) begin
        m_uf = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (pop) begin
        void'(q.pop_front());
        m_consumed++;
      end
      if (fly.size() > 0) q.push_back(fly.pop_front());
      if (e_rden) begin
        fly.push_back(mem[e_addr]);
        m_issued++;
      end
      case (m_ph)
        0: if (start) begin
          m_base = int'(baseAddr); m_n = int'(numWeights); m_vin = vmemInit;
          m_issued = 0; m_consumed = 0; m_uf = 0; m_cnt = 0; nph = 1;
        end
        1: if (old_cons == m_n) begin nph = 2; m_hold = FH; end
        2: begin
          if (m_hold > 0) m_hold--;
          if (m_hold == 0 && !readyMem) nph = 3;
        end
        3: begin m_vres = neurVmem; m_sres = neurSpike; nph = 4; end
        default: nph = 0;
      endcase
      m_ph = nph;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready after `delay` stream cycles; 1: bit pattern then ready; 2: random.
  task automatic run_job(input logic [9:0] b, input logic [9:0] n, input logic [15:0] vi,
                         input int mode, input int delay, input logic [7:0] pat,
                         input logic [15:0] nv, input logic nsp);
    int k, guard;
    baseAddr = b; numWeights = n; vmemInit = vi; neurVmem = nv; neurSpike = nsp;
    obs_reads = 0; obs_fin = 0; obs_pops = 0; obs_done = 0;
    start = 1'b1; readyMem = 1'b0;
    cycle();
    start = 1'b0;
    k = 0; guard = 0;
    while (m_ph != 0 && guard < 400) begin
      if (m_ph == 1) begin
        case (mode)
          0:       readyMem = (k >= delay);
          1:       readyMem = (k < 8) ? pat[k] : 1'b1;
          default: readyMem = 1'($urandom_range(0, 1));
        endcase
        k++;
      end else begin
        readyMem = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (mode == 2) begin
        // Inputs latched at start must not leak into a running job.
        baseAddr = 10'($urandom); numWeights = 10'($urandom); vmemInit = 16'($urandom);
        start = (m_ph >= 1 && m_ph <= 3) && ($urandom_range(0, 7) == 0);
      end
      cycle();
      guard++;
    end
    start = 1'b0; readyMem = 1'b0;
    if (m_ph != 0) begin
      n_vec++; n_bad++;
      $display("FAIL job_timeout: got phase %0d expected 0 within 400 cycles", m_ph);
      reset = 1'b1; cycle(); reset = 1'b0;
    end
  endtask

  typedef struct {
    logic [9:0] b; logic [9:0] n; logic [15:0] vi; int mode; int delay; logic [7:0] pat;
    logic [15:0] nv; logic ns;
    int e_reads; int e_pops; int e_fin; int e_uf; int e_cnt;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{10'h010, 10'd5, 16'h0123, 0, 2, 8'h00, 16'h0180, 1'b1, 5, 5, FH, 0, 0};
    tbl[1] = '{10'h200, 10'd0, 16'h0042, 0, 0, 8'h00, 16'h7F00, 1'b0, 0, 0, FH, 0, 0};
    tbl[2] = '{10'h100, 10'd3, 16'h1111, 1, 0, 8'b1110_0001, 16'h0001, 1'b0, 3, 3, FH, 1, 1};
    tbl[3] = '{10'h080, 10'd3, 16'h2222, 1, 0, 8'b1110_1001, 16'hBEEF, 1'b1, 3, 3, FH, 1, 1};
    tbl[4] = '{10'h3FE, 10'd4, 16'h3333, 0, 2, 8'h00, 16'h0F0F, 1'b0, 4, 4, FH, 0, 0};

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11) | 8'h01;
    for (int i = 0; i < 5; i++) mem[16 + i] = 8'(i + 1);

    start = 0; readyMem = 0; baseAddr = '0; numWeights = '0; vmemInit = '0;
    neurVmem = '0; neurSpike = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    chk("reset_busy", int'(busy), 0);
    chk("reset_finished", int'(finished), 0);
    chk("reset_memRdEn", int'(memRdEn), 0);
    chk("reset_vmemResult", int'(vmemResult), 0);
    cycle();
    cycle();

    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i].b, tbl[i].n, tbl[i].vi, tbl[i].mode, tbl[i].delay, tbl[i].pat,
              tbl[i].nv, tbl[i].ns);
      chk($sformatf("job%0d_reads", i), obs_reads, tbl[i].e_reads);
      chk($sformatf("job%0d_pops", i), obs_pops, tbl[i].e_pops);
      chk($sformatf("job%0d_finished_cycles", i), obs_fin, tbl[i].e_fin);
      chk($sformatf("job%0d_done_pulses", i), obs_done, 1);
      chk($sformatf("job%0d_underflow", i), int'(underflow), tbl[i].e_uf);
      chk($sformatf("job%0d_vmemResult", i), int'(vmemResult), int'(tbl[i].nv));
      chk($sformatf("job%0d_spikeResult", i), int'(spikeResult), int'(tbl[i].ns));
      chk($sformatf("job%0d_vmemIn", i), int'(vmemIn), int'(tbl[i].vi));
`ifdef FEEDER_UNDERFLOW_CNT_EN
      chk($sformatf("job%0d_underflowCount", i), int'(underflowCount), tbl[i].e_cnt);
`endif
      cycle();
    end

    // Abort mid-stream on the wrapping job after the second pop.
    baseAddr = 10'h3FE; numWeights = 10'd4; vmemInit = 16'h5A5A;
    obs_pops = 0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int k = 0; k < 20 && obs_pops < 2; k++) begin
      readyMem = (k >= 2);
      cycle();
    end
    chk("abort_pops_before_reset", obs_pops, 2);
    reset = 1'b1; readyMem = 1'b0;
    cycle();
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_finished", int'(finished), 0);
    chk("abort_memRdEn", int'(memRdEn), 0);
    chk("abort_memAddr", int'(memAddr), 0);
    chk("abort_weightData", int'(weightData), 0);
    chk("abort_vmemIn", int'(vmemIn), 0);
    chk("abort_vmemResult", int'(vmemResult), 0);
    chk("abort_underflow", int'(underflow), 0);
    repeat (3) cycle();

    for (int j = 0; j < 40; j++) begin
      run_job(10'($urandom), 10'($urandom_range(0, 8)), 16'($urandom), 2, 0, 8'h00,
              16'($urandom), 1'($urandom_range(0, 1)));
      chk($sformatf("rand%0d_done_pulses", j), obs_done, 1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
